mem_port_arbiter: RTL

//  Shares the core's single memory bus between instruction fetch (I port) and load/store (D port).

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch (I) and load/store (D).
// D has priority with a starvation guard for I; responses are routed back in order via a tag FIFO.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid_i,
  output logic            i_ready_o,
  input  logic [AW-1:0]   i_addr_i,
  input  logic            d_valid_i,
  output logic            d_ready_o,
  input  logic [AW-1:0]   d_addr_i,
  input  logic            d_we_i,
  input  logic [DW-1:0]   d_wdata_i,
  input  logic [DW/8-1:0] d_wstrb_i,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [AW-1:0]   m_addr_o,
  output logic            m_we_o,
  output logic [DW-1:0]   m_wdata_o,
  output logic [DW/8-1:0] m_wstrb_o,
  input  logic            m_rvalid_i,
  input  logic [DW-1:0]   m_rdata_i,
  output logic            i_rvalid_o,
  output logic            d_rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned TW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]      out_cnt;
  logic [TW-1:0]      starve_cnt;
  logic [MAX_OUT-1:0] tag_mem;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               cke;
  logic               allow;
  logic               starved;
  logic               win_i;
  logic               win_d;
  logic               accept;
  logic               pop;
  logic               head_tag;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant decision; capacity uses the pre-update outstanding count.
  always_comb begin
    cke      = ~m_valid_o | m_ready_i;
    allow    = cke && (out_cnt < CW'(MAX_OUT));
    starved  = (starve_cnt == TW'(STARVE_LIMIT)) && i_valid_i;
    win_i    = allow && i_valid_i && (starved || !d_valid_i);
    win_d    = allow && d_valid_i && !starved;
    accept   = win_i | win_d;
    head_tag = tag_mem[rd_ptr];
    pop      = m_rvalid_i && (out_cnt != '0);
  end

  assign i_ready_o  = win_i;
  assign d_ready_o  = win_d;
  assign i_rvalid_o = pop & ~head_tag;
  assign d_rvalid_o = pop & head_tag;
  assign rdata_o    = m_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_o  <= 1'b0;
      m_addr_o   <= '0;
      m_we_o     <= 1'b0;
      m_wdata_o  <= '0;
      m_wstrb_o  <= '0;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
      err_o      <= 1'b0;
    end else begin
      // Bus request register: holds while the bus stalls it.
      if (cke) begin
        m_valid_o <= accept;
        if (win_d) begin
          m_addr_o  <= d_addr_i;
          m_we_o    <= d_we_i;
          m_wdata_o <= d_wdata_i;
          m_wstrb_o <= d_wstrb_i;
        end else if (win_i) begin
          m_addr_o  <= i_addr_i;
          m_we_o    <= 1'b0;
          m_wdata_o <= '0;
          m_wstrb_o <= '0;
        end
      end
      if (accept) begin
        tag_mem[wr_ptr] <= win_d;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (accept && !pop) begin
        out_cnt <= out_cnt + CW'(1);
      end else if (!accept && pop) begin
        out_cnt <= out_cnt - CW'(1);
      end
      if (win_d && i_valid_i) begin
        if (starve_cnt != TW'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + TW'(1);
        end
      end else if (win_i) begin
        starve_cnt <= '0;
      end
      if (m_rvalid_i && (out_cnt == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
